// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin I/D cache arbiter for the shared main-memory block port
module mem_port_arbiter #(
    parameter int ADDR_W         = 4,
    parameter int BLOCK_W        = 64,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic [ADDR_W-1:0]  i_index,
    output logic               i_done,
    input  logic               d_load,
    input  logic               d_write,
    input  logic [ADDR_W-1:0]  d_index,
    input  logic [BLOCK_W-1:0] d_wdata,
    output logic               d_done,
    output logic [BLOCK_W-1:0] rdata,
    output logic               mem_load,
    output logic               mem_write,
    output logic [ADDR_W-1:0]  mem_index,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic               mem_done,
    input  logic [BLOCK_W-1:0] mem_rdata,
    output logic               timeout_err,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit WDOG_EN = (TIMEOUT_CYCLES != 0);

    state_t             state, state_nxt;
    logic               grant_d, last_d, op_write, timed_out;
    logic [CNT_W-1:0]   cnt;
    logic               i_pend, d_pend, pick_d, expire;

    // D wins only when I is idle or I was served last; reset leaves last_d set so I wins the first tie
    always_comb begin
        i_pend = i_load;
        d_pend = d_load | d_write;
        pick_d = d_pend && (!i_pend || !last_d);
        expire = WDOG_EN && !mem_done && (cnt == CNT_LAST);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (i_pend || d_pend)   state_nxt = BUSY;
            BUSY:    if (mem_done || expire) state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state == BUSY) || (state == RELEASE);
        mem_load    = (state == BUSY) && !op_write;
        mem_write   = (state == BUSY) && op_write;
        i_done      = (state == RELEASE) && !grant_d;
        d_done      = (state == RELEASE) && grant_d;
        timeout_err = (state == RELEASE) && timed_out;
    end

    // A pending write outranks a simultaneous D load; the load stays pending for a later grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_d   <= 1'b0;
            last_d    <= 1'b1;
            op_write  <= 1'b0;
            timed_out <= 1'b0;
            cnt       <= '0;
            mem_index <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
        end else begin
            case (state)
                IDLE: if (i_pend || d_pend) begin
                    grant_d   <= pick_d;
                    last_d    <= pick_d;
                    op_write  <= pick_d && d_write;
                    mem_index <= pick_d ? d_index : i_index;
                    mem_wdata <= (pick_d && d_write) ? d_wdata : '0;
                    cnt       <= '0;
                    timed_out <= 1'b0;
                end
                BUSY: if (mem_done) begin
                    if (!op_write) rdata <= mem_rdata;
                end else begin
                    if (WDOG_EN) cnt <= cnt + 1'b1;
                    timed_out <= expire;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

    localparam int ADDR_W  = 4;
    localparam int BLOCK_W = 64;
    localparam int TO      = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               i_load, d_load, d_write;
    logic [ADDR_W-1:0]  i_index, d_index;
    logic [BLOCK_W-1:0] d_wdata;
    logic               i_done, d_done;
    logic [BLOCK_W-1:0] rdata;
    logic               mem_load, mem_write;
    logic [ADDR_W-1:0]  mem_index;
    logic [BLOCK_W-1:0] mem_wdata;
    logic               mem_done;
    logic [BLOCK_W-1:0] mem_rdata;
    logic               timeout_err, busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .i_load(i_load), .i_index(i_index), .i_done(i_done),
        .d_load(d_load), .d_write(d_write), .d_index(d_index), .d_wdata(d_wdata), .d_done(d_done),
        .rdata(rdata), .mem_load(mem_load), .mem_write(mem_write), .mem_index(mem_index),
        .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .timeout_err(timeout_err), .busy(busy)
    );

    typedef struct {
        bit                 is_d;
        bit                 wr;
        logic [ADDR_W-1:0]  idx;
        logic [BLOCK_W-1:0] wdata;
        logic [BLOCK_W-1:0] rdata;
        bit                 to;
    } txn_t;

    txn_t               sb[$];
    txn_t               mon_e;
    int                 n_checks = 0;
    int                 n_fail   = 0;
    logic [BLOCK_W-1:0] mem_arr[16];
    logic [BLOCK_W-1:0] exp_arr[16];
    logic [BLOCK_W-1:0] exp_last = '0;
    int                 lat = 3;
    int                 rcnt = 0;
    bit                 spur = 0;
    bit                 hold_rel = 0;
    bit                 held = 0;
    bit                 cmd_seen = 0;
    int                 cc, bc;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input bit is_d, input bit wr, input logic [ADDR_W-1:0] idx,
                        input logic [BLOCK_W-1:0] wd, input bit to);
        txn_t t;
        t.is_d = is_d; t.wr = wr; t.idx = idx; t.wdata = wd; t.to = to;
        t.rdata = (!wr && !to) ? exp_arr[idx] : exp_last;
        exp_last = t.rdata;
        if (wr && !to) exp_arr[idx] = wd;
        sb.push_back(t);
    endtask

    task automatic run_one(output int cmd_cyc, output int busy_cyc);
        bit got = 0;
        cmd_cyc = 0;
        busy_cyc = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (mem_load || mem_write) cmd_cyc++;
            if (busy) busy_cyc++;
            if (i_done || d_done) got = 1;
        end
        check("done_seen", got, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        exp_last = '0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Main-memory model: answers after lat BUSY cycles (lat=0 never answers)
    initial begin
        mem_done = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (spur) mem_done = 1'b1;
            else if (mem_load || mem_write) begin
                rcnt++;
                if (lat != 0 && rcnt == lat) begin
                    mem_done = 1'b1;
                    if (mem_load) mem_rdata = mem_arr[mem_index];
                    else          mem_arr[mem_index] = mem_wdata;
                end else mem_done = 1'b0;
            end else begin
                rcnt = 0;
                if (hold_rel && mem_done && !held) held = 1;
                else begin
                    held = 0;
                    mem_done = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (!reset) cmd_seen = 0;
            else begin
                if ((mem_load || mem_write) && !cmd_seen) begin
                    cmd_seen = 1;
                    if (sb.size() == 0) check("unexpected_cmd", 1, 0);
                    else begin
                        check("cmd_write", mem_write, sb[0].wr);
                        check("cmd_index", mem_index, sb[0].idx);
                        if (sb[0].wr) check("cmd_wdata", mem_wdata, sb[0].wdata);
                    end
                end
                if (mem_load || mem_write) check("cmd_onehot", mem_load & mem_write, 0);
                if (i_done || d_done) begin
                    cmd_seen = 0;
                    check("done_onehot", i_done & d_done, 0);
                    if (sb.size() == 0) check("unexpected_done", 1, 0);
                    else begin
                        mon_e = sb.pop_front();
                        check("done_requester", d_done, mon_e.is_d);
                        check("timeout_err", timeout_err, mon_e.to);
                        check("rdata", rdata, mon_e.rdata);
                    end
                end else if (timeout_err) check("timeout_without_done", 1, 0);
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem_arr[i] = {32'hC0DE_0000 | i, 32'h0000_1000 + i};
            exp_arr[i] = mem_arr[i];
        end
        mem_arr[0] = 64'hA5A5_0000_5A5A_1111;
        exp_arr[0] = 64'hA5A5_0000_5A5A_1111;
        reset = 1'b0;
        i_load = 0; d_load = 0; d_write = 0;
        i_index = '0; d_index = '0; d_wdata = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_mem_load", mem_load, 0);
        check("rst_mem_write", mem_write, 0);
        check("rst_dones", {i_done, d_done, timeout_err}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_mem_index", mem_index, 0);
        reset = 1'b1;

        // single I-cache load, memory answers after 3 cycles
        @(negedge clk);
        lat = 3;
        push(0, 0, 4'h0, '0, 0);
        i_index = 4'h0; i_load = 1;
        run_one(cc, bc);
        check("t1_cmd_cycles", cc, 3);
        check("t1_busy_cycles", bc, 4);
        @(posedge clk); #1 i_load = 0;

        // contending loads alternate I, D, I, D after reset
        do_reset();
        @(negedge clk);
        lat = 2;
        push(0, 0, 4'h1, '0, 0);
        push(1, 0, 4'h2, '0, 0);
        push(0, 0, 4'h1, '0, 0);
        push(1, 0, 4'h2, '0, 0);
        i_index = 4'h1; d_index = 4'h2; i_load = 1; d_load = 1;
        for (int n = 0; n < 4; n++) run_one(cc, bc);
        @(posedge clk); #1 i_load = 0; d_load = 0;

        // write before load on the D side
        @(negedge clk);
        push(1, 1, 4'h9, 64'h1234, 0);
        push(1, 0, 4'h9, '0, 0);
        d_index = 4'h9; d_wdata = 64'h1234; d_write = 1; d_load = 1;
        run_one(cc, bc);
        @(posedge clk); #1 d_write = 0;
        run_one(cc, bc);
        @(posedge clk); #1 d_load = 0;

        // watchdog abort
        @(negedge clk);
        lat = 0;
        push(0, 0, 4'h5, '0, 1);
        i_index = 4'h5; i_load = 1;
        run_one(cc, bc);
        check("t4_cmd_cycles", cc, TO);
        check("t4_busy_cycles", bc, TO + 1);
        @(posedge clk); #1 i_load = 0;
        @(negedge clk);
        check("t4_idle_busy", busy, 0);

        // asynchronous reset in the middle of a write
        lat = 10;
        push(1, 1, 4'h3, 64'hDEAD_BEEF_0000_0003, 0);
        d_index = 4'h3; d_wdata = 64'hDEAD_BEEF_0000_0003; d_write = 1;
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("t5_async_mem_write", mem_write, 0);
        check("t5_async_busy", busy, 0);
        sb[0].rdata = '0;
        exp_last = '0;
        @(negedge clk);
        check("t5_no_d_done", d_done, 0);
        lat = 3;
        reset = 1'b1;
        run_one(cc, bc);
        check("t5_reservice_cycles", cc, 3);
        @(posedge clk); #1 d_write = 0;

        // spurious mem_done in IDLE, then mem_done held through RELEASE
        @(negedge clk);
        spur = 1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t6_spur_busy", busy, 0);
            check("t6_spur_done", {i_done, d_done}, 0);
        end
        spur = 0;
        hold_rel = 1;
        lat = 2;
        push(0, 0, 4'h7, '0, 0);
        i_index = 4'h7; i_load = 1;
        run_one(cc, bc);
        @(posedge clk); #1 i_load = 0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check("t6_hold_busy", busy, 0);
        end
        hold_rel = 0;

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
